debug_text_overlay: RTL and testbench
=====================================

# debug_text_overlay

Parametrised on-screen debug text overlay. It sits in the video output path just before the HDMI encoder and replaces the fixed version-string overlay. A writable ROWS×COLS character buffer is loaded through a valid/ready port, and each glyph is rendered at an integer power-of-two scale with a per-cell blink attribute. The RGB stream passes through a fixed 3-stage pipeline so that latency is identical whether or not a pixel is overlaid.

## Interface
- `COLS`, 16: characters per text row, 1..32.
- `ROWS`, 2: text rows, 1..8.
- `X_OFFSET`, 16: left edge of the overlay, in screen pixels.
- `Y_OFFSET`, 24: top edge of the overlay, in screen pixels.
- `SCALE_LOG2`, 0: glyph pixel size is `1<<SCALE_LOG2`. Legal range 0..2.
- `FG_COLOR`, 24'hFFFFFF: overlay colour, ordered {R,G,B}.
- `BLINK_FRAMES`, 32: frames per blink half-period, ≥1.
- `ENABLE`, 1'b1: when 0, no pixel is ever overlaid. The pipeline is kept.
- `clk_i`  in  1  pixel clock. This is the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `screen_x_i`, `screen_y_i`  in  10 each  current pixel coordinate.
- `frame_start_i`  in  1  one-cycle pulse at the start of each frame.
- `r_i`, `g_i`, `b_i`  in  8 each  upstream pixel.
- `wr_valid_i`  in  1  character write request.
- `wr_ready_o`  out  1  write can be accepted.
- `wr_addr_i`  in  AW  cell index, where `row*COLS+col`, `AW=$clog2(COLS*ROWS)`.
- `wr_char_i`  in  8  cell data. Bit 7 is the blink attribute. Bits 4:0 are the glyph code.
- `clr_i`  in  1  request a clear of the whole buffer.
- `busy_o`  out  1  a clear is in progress.
- `r_o`, `g_o`, `b_o`  out  8 each  composited pixel.

## Operation
- Glyph codes:
  - 0x00–0x0F render hex digits 0–F.
  - 0x10 is space.
  - 0x11 is '-', 0x12 is ':', 0x13 is '.'.
  - 0x14–0x1F render a solid block.
- Each glyph is 8×8 pixels. Bit 7 of a font row is the leftmost pixel.
- Coordinate decode:
  - `rel = screen − OFFSET`, checked against `screen ≥ OFFSET`, 10-bit arithmetic.
  - `rel_s = rel >> SCALE_LOG2`.
  - col = `rel_s_x[..:3]` and row = `rel_s_y[..:3]`.
  - The pixel is in range only when `col < COLS` and `row < ROWS`.
- Pixel-on condition: ENABLE, in range, FSM in IDLE, and the font bit is set.
  - A cell with the blink attribute set is treated as space while `blink_phase = 1`.
- Output when the pixel is on: FG_COLOR. Otherwise the delayed `r_i`/`g_i`/`b_i`.
- Character buffer: simple dual-port RAM, COLS·ROWS × 8. Write port and scan read port are independent.
  - A read and a write to the same address in the same cycle return the old data.
- Write handshake: a transfer occurs on an edge where `wr_valid_i && wr_ready_o`.
  - A write with `wr_addr_i ≥ COLS*ROWS` completes the handshake, but its data is dropped.
- FSM states:
  - **CLEAR** is entered on reset. It writes 8'h10 to cells 0..COLS·ROWS−1, one cell per cycle, then moves to IDLE.
  - **IDLE** keeps `wr_ready_o=1`. If `clr_i` is high, it moves to CLEAR on the next edge with the clear address at 0.
  - If a write handshake and `clr_i` occur on the same edge, the write completes and is then overwritten by the clear.
  - `clr_i` is ignored while in CLEAR.
- Blink: a frame counter increments on `frame_start_i`. When it reaches `BLINK_FRAMES−1` it wraps to 0 and toggles `blink_phase`.

## Timing
- Reset state:
  - `r_o`/`g_o`/`b_o` = 0.
  - `wr_ready_o` = 0, `busy_o` = 1.
  - FSM = CLEAR, clear address 0.
  - Frame counter 0, `blink_phase` = 0.
- After reset release, `busy_o` stays high for exactly COLS·ROWS cycles. `wr_ready_o` rises on the same edge that `busy_o` falls.
  - Reasserting `reset_n` mid-clear restarts the clear from 0.
- `wr_ready_o` and `busy_o` are registered outputs and are complementary.
- Pixel latency: inputs sampled at edge k appear on the outputs after edge k+2.
  - Stage 1 registers the decode, cell address, x/y bits and RGB.
  - Stage 2 is the RAM read plus delayed signals.
  - Stage 3 is the font lookup and output mux.
- A write accepted at edge k is visible to the scan for coordinates sampled at edge k+1 or later.
- `blink_phase` is sampled at stage 3.

## Structure
- Package `debug_overlay_pkg` holds:
  - the glyph code constants (`GLYPH_SPACE`, `GLYPH_DASH`, …);
  - the 20×8 font ROM constant;
  - the FSM state enum {IDLE, CLEAR}.
- One sub-module, `debug_char_ram`: parametrised simple dual-port RAM with synchronous read.

## Test plan
- Reset release with COLS=16, ROWS=2 → `busy_o` high for 32 cycles. After that, every in-range pixel equals the input (all cells are space). `wr_ready_o`=1.
- Write addr 0 = 0x0A, then scan x=16..23, y=24..31 with input RGB 0x000000 → output matches the 'A' font bits, FG pixels 0xFFFFFF. The x=16 pixel appears three edges after the input is applied.
- SCALE_LOG2=1, write cell 17 (row 1, col 1) = 0x14 → a solid block covers x=32..47, y=40..55. x=48 passes through.
- Write addr 40 (out of range) with data 0x14 → handshake completes and no pixel changes anywhere.
- `clr_i` asserted together with a write → the write completes, `busy_o` is high for COLS·ROWS cycles, and the written cell then reads as space.
- Cell 0 = 0x81, BLINK_FRAMES=2, pulse `frame_start_i` 4× → the glyph is visible for frames 0–1, hidden for 2–3, and visible again from frame 4.

Source files
------------

// File: rtl/debug_overlay_pkg.sv
// debug_overlay_pkg
// Shared definitions for the debug text overlay:
//   - glyph code constants for the non-digit glyphs
//   - the 20-entry 8x8 font ROM (hex digits, space, '-', ':', '.')
//   - the control FSM state type
//   - glyph_row(): font row lookup that also covers the solid-block codes
package debug_overlay_pkg;

  localparam logic [4:0] GLYPH_SPACE = 5'h10;
  localparam logic [4:0] GLYPH_DASH  = 5'h11;
  localparam logic [4:0] GLYPH_COLON = 5'h12;
  localparam logic [4:0] GLYPH_DOT   = 5'h13;
  localparam logic [4:0] GLYPH_BLOCK = 5'h14;

  // Buffer value written by a clear: blink attribute off, glyph space.
  localparam logic [7:0] SPACE_CHAR = {3'b000, GLYPH_SPACE};

  localparam int FONT_GLYPHS = 20;

  // Bit 7 of every row is the leftmost pixel of the glyph.
  localparam logic [7:0] FONT_ROM [FONT_GLYPHS][8] = '{
    '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00},  // 0
    '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00},  // 1
    '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00},  // 2
    '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},  // 3
    '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00},  // 4
    '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00},  // 5
    '{8'h3C, 8'h66, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h3C, 8'h00},  // 6
    '{8'h7E, 8'h66, 8'h0C, 8'h18, 8'h18, 8'h18, 8'h18, 8'h00},  // 7
    '{8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00},  // 8
    '{8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h66, 8'h3C, 8'h00},  // 9
    '{8'h18, 8'h3C, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h66, 8'h00},  // A
    '{8'h7C, 8'h66, 8'h66, 8'h7C, 8'h66, 8'h66, 8'h7C, 8'h00},  // B
    '{8'h3C, 8'h66, 8'h60, 8'h60, 8'h60, 8'h66, 8'h3C, 8'h00},  // C
    '{8'h78, 8'h6C, 8'h66, 8'h66, 8'h66, 8'h6C, 8'h78, 8'h00},  // D
    '{8'h7E, 8'h60, 8'h60, 8'h78, 8'h60, 8'h60, 8'h7E, 8'h00},  // E
    '{8'h7E, 8'h60, 8'h60, 8'h78, 8'h60, 8'h60, 8'h60, 8'h00},  // F
    '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},  // space
    '{8'h00, 8'h00, 8'h00, 8'h7E, 8'h00, 8'h00, 8'h00, 8'h00},  // '-'
    '{8'h00, 8'h18, 8'h18, 8'h00, 8'h18, 8'h18, 8'h00, 8'h00},  // ':'
    '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h18, 8'h18, 8'h00}   // '.'
  };

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } overlay_state_t;

  // Codes from GLYPH_BLOCK upward have no ROM entry; they all render solid.
  function automatic logic [7:0] glyph_row(input logic [4:0] code,
                                           input logic [2:0] row);
    logic [7:0] bits;
    if (code >= GLYPH_BLOCK) begin
      bits = 8'hFF;
    end else begin
      bits = FONT_ROM[code][row];
    end
    return bits;
  endfunction

endpackage

// File: rtl/debug_char_ram.sv
// debug_char_ram
// Simple dual-port character RAM with one write port and one synchronous
// read port on the same clock. A read and a write to the same address on the
// same edge return the previous contents.
//   clk    : clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address, sampled on the clock edge
//   rdata  : read data, registered
module debug_char_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset on the storage or read register so the array maps onto block RAM;
  // the clear sequence of the owner initialises the contents instead.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/debug_text_overlay.sv
// debug_text_overlay
// On-screen debug text overlay placed in the video path ahead of the HDMI
// encoder. A ROWS x COLS character buffer is rendered at X_OFFSET/Y_OFFSET with
// 8x8 glyphs scaled by 1<<SCALE_LOG2. RGB always takes three register stages
// so overlaid and pass-through pixels have identical latency.
//   clk_i, reset_n           : pixel clock, asynchronous active-low reset
//   screen_x_i, screen_y_i   : current pixel coordinate
//   frame_start_i            : one-cycle pulse per frame, drives blinking
//   r_i, g_i, b_i            : upstream pixel
//   wr_valid_i, wr_ready_o   : character write handshake
//   wr_addr_i, wr_char_i     : cell index (row*COLS+col) and cell data
//                              (bit 7 blink, bits 4:0 glyph)
//   clr_i, busy_o            : whole-buffer clear request and clear-in-progress
//   r_o, g_o, b_o            : composited pixel
module debug_text_overlay
  import debug_overlay_pkg::*;
#(
  parameter int          COLS         = 16,
  parameter int          ROWS         = 2,
  parameter int          X_OFFSET     = 16,
  parameter int          Y_OFFSET     = 24,
  parameter int          SCALE_LOG2   = 0,
  parameter logic [23:0] FG_COLOR     = 24'hFFFFFF,
  parameter int          BLINK_FRAMES = 32,
  parameter bit          ENABLE       = 1'b1,
  localparam int         CELLS        = COLS * ROWS,
  localparam int         AW           = (CELLS > 1) ? $clog2(CELLS) : 1
) (
  input  logic          clk_i,
  input  logic          reset_n,
  input  logic [9:0]    screen_x_i,
  input  logic [9:0]    screen_y_i,
  input  logic          frame_start_i,
  input  logic [7:0]    r_i,
  input  logic [7:0]    g_i,
  input  logic [7:0]    b_i,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_char_i,
  input  logic          clr_i,
  output logic          busy_o,
  output logic [7:0]    r_o,
  output logic [7:0]    g_o,
  output logic [7:0]    b_o
);

  localparam logic [9:0]    X_OFF     = 10'(X_OFFSET);
  localparam logic [9:0]    Y_OFF     = 10'(Y_OFFSET);
  localparam logic [6:0]    COLS_L    = 7'(COLS);
  localparam logic [6:0]    ROWS_L    = 7'(ROWS);
  localparam logic [AW:0]   CELLS_L   = (AW + 1)'(CELLS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);
  localparam int            FCW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(BLINK_FRAMES - 1);

  overlay_state_t state;
  logic [AW-1:0]  clr_addr;

  logic [FCW-1:0] frame_cnt;
  logic           blink_phase;

  // Coordinate decode (feeds stage 1)
  logic [9:0]    rel_x;
  logic [9:0]    rel_y;
  logic [9:0]    rel_sx;
  logic [9:0]    rel_sy;
  logic [6:0]    cell_col;
  logic [6:0]    cell_row;
  logic [AW-1:0] cell_addr;
  logic          in_range;

  // Pipeline registers
  logic          s1_show;
  logic [AW-1:0] s1_addr;
  logic [2:0]    s1_px;
  logic [2:0]    s1_py;
  logic [23:0]   s1_rgb;
  logic          s2_show;
  logic [2:0]    s2_px;
  logic [2:0]    s2_py;
  logic [23:0]   s2_rgb;
  logic [7:0]    rd_char;

  // Stage 3 glyph evaluation
  logic [4:0]    shown_code;
  logic [7:0]    font_bits;
  logic          pixel_on;
  logic [1:0]    unused_attr_bits;

  // RAM write port
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [7:0]    ram_wdata;
  logic          wr_addr_ok;

  assign unused_attr_bits = rd_char[6:5];

  // The subtraction wraps for pixels left of / above the overlay; the
  // screen >= offset terms reject those before the column/row tests.
  always_comb begin
    rel_x     = screen_x_i - X_OFF;
    rel_y     = screen_y_i - Y_OFF;
    rel_sx    = rel_x >> SCALE_LOG2;
    rel_sy    = rel_y >> SCALE_LOG2;
    cell_col  = rel_sx[9:3];
    cell_row  = rel_sy[9:3];
    in_range  = (screen_x_i >= X_OFF) && (screen_y_i >= Y_OFF) &&
                (cell_col < COLS_L) && (cell_row < ROWS_L);
    cell_addr = AW'({9'd0, cell_row} * 16'(COLS) + {9'd0, cell_col});
  end

  // Out-of-range addresses still complete the handshake but never write.
  always_comb begin
    wr_addr_ok = ({1'b0, wr_addr_i} < CELLS_L);
    ram_we     = 1'b0;
    ram_waddr  = wr_addr_i;
    ram_wdata  = wr_char_i;
    if (state == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr;
      ram_wdata = SPACE_CHAR;
    end else begin
      ram_we = wr_valid_i && wr_ready_o && wr_addr_ok;
    end
  end

  // Control FSM. wr_ready_o and busy_o are registered alongside the state so
  // they change on the same edge as the state and stay complementary.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state      <= CLEAR;
      clr_addr   <= '0;
      wr_ready_o <= 1'b0;
      busy_o     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (clr_i) begin
            state      <= CLEAR;
            clr_addr   <= '0;
            wr_ready_o <= 1'b0;
            busy_o     <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_addr == LAST_ADDR) begin
            state      <= IDLE;
            clr_addr   <= '0;
            wr_ready_o <= 1'b1;
            busy_o     <= 1'b0;
          end else begin
            clr_addr <= clr_addr + AW'(1);
          end
        end
        default: begin
          state      <= CLEAR;
          clr_addr   <= '0;
          wr_ready_o <= 1'b0;
          busy_o     <= 1'b1;
        end
      endcase
    end
  end

  // Blink timebase: blink_phase flips every BLINK_FRAMES frame starts.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start_i) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + FCW'(1);
      end
    end
  end

  debug_char_ram #(
    .DEPTH(CELLS),
    .WIDTH(8)
  ) u_char_ram (
    .clk   (clk_i),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (s1_addr),
    .rdata (rd_char)
  );

  // A blinking cell in its hidden half-period renders as space.
  always_comb begin
    shown_code = rd_char[4:0];
    if (rd_char[7] && blink_phase) begin
      shown_code = GLYPH_SPACE;
    end
    font_bits = glyph_row(shown_code, s2_py);
    pixel_on  = s2_show && font_bits[3'd7 - s2_px];
  end

  // Three-stage pixel pipeline: decode, RAM read, font lookup and output mux.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      s1_show <= 1'b0;
      s1_addr <= '0;
      s1_px   <= '0;
      s1_py   <= '0;
      s1_rgb  <= '0;
      s2_show <= 1'b0;
      s2_px   <= '0;
      s2_py   <= '0;
      s2_rgb  <= '0;
      r_o     <= '0;
      g_o     <= '0;
      b_o     <= '0;
    end else begin
      s1_show <= ENABLE && in_range && (state == IDLE);
      s1_addr <= cell_addr;
      s1_px   <= rel_sx[2:0];
      s1_py   <= rel_sy[2:0];
      s1_rgb  <= {r_i, g_i, b_i};
      s2_show <= s1_show;
      s2_px   <= s1_px;
      s2_py   <= s1_py;
      s2_rgb  <= s1_rgb;
      r_o     <= pixel_on ? FG_COLOR[23:16] : s2_rgb[23:16];
      g_o     <= pixel_on ? FG_COLOR[15:8]  : s2_rgb[15:8];
      b_o     <= pixel_on ? FG_COLOR[7:0]   : s2_rgb[7:0];
    end
  end

endmodule

// File: tb/tb_debug_text_overlay.sv
// tb_debug_text_overlay
// Directed bench for debug_text_overlay. Two instances share the video inputs:
//   dut0: 16x2 cells, scale 1x, blink every 2 frames
//   dut1: 20x2 cells (40 cells, so address 40 is representable but out of
//         range), scale 2x
// Each instance has its own write/clear port.
module tb_debug_text_overlay;

  logic       clk;
  logic       reset_n;
  logic [9:0] screen_x;
  logic [9:0] screen_y;
  logic       frame_start;
  logic [7:0] r_in;
  logic [7:0] g_in;
  logic [7:0] b_in;

  logic       wr_valid0;
  logic [4:0] wr_addr0;
  logic [7:0] wr_char0;
  logic       clr0;
  logic       ready0;
  logic       busy0;
  logic [7:0] r0, g0, b0;

  logic       wr_valid1;
  logic [5:0] wr_addr1;
  logic [7:0] wr_char1;
  logic       clr1;
  logic       ready1;
  logic       busy1;
  logic [7:0] r1, g1, b1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] rgb;
    logic [23:0] exp0;
    logic [23:0] exp1;
  } vec_t;

  vec_t vecs[$];

  logic [7:0] font_a [8];

  debug_text_overlay #(
    .COLS(16), .ROWS(2), .X_OFFSET(16), .Y_OFFSET(24), .SCALE_LOG2(0),
    .FG_COLOR(24'hFFFFFF), .BLINK_FRAMES(2), .ENABLE(1'b1)
  ) dut0 (
    .clk_i(clk), .reset_n(reset_n),
    .screen_x_i(screen_x), .screen_y_i(screen_y), .frame_start_i(frame_start),
    .r_i(r_in), .g_i(g_in), .b_i(b_in),
    .wr_valid_i(wr_valid0), .wr_ready_o(ready0), .wr_addr_i(wr_addr0),
    .wr_char_i(wr_char0), .clr_i(clr0), .busy_o(busy0),
    .r_o(r0), .g_o(g0), .b_o(b0)
  );

  debug_text_overlay #(
    .COLS(20), .ROWS(2), .X_OFFSET(16), .Y_OFFSET(24), .SCALE_LOG2(1),
    .FG_COLOR(24'hFFFFFF), .BLINK_FRAMES(2), .ENABLE(1'b1)
  ) dut1 (
    .clk_i(clk), .reset_n(reset_n),
    .screen_x_i(screen_x), .screen_y_i(screen_y), .frame_start_i(frame_start),
    .r_i(r_in), .g_i(g_in), .b_i(b_in),
    .wr_valid_i(wr_valid1), .wr_ready_o(ready1), .wr_addr_i(wr_addr1),
    .wr_char_i(wr_char1), .clr_i(clr1), .busy_o(busy1),
    .r_o(r1), .g_o(g1), .b_o(b1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the summary");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", name, got, expv);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y,
                               input logic [23:0] rgb);
    screen_x = x;
    screen_y = y;
    {r_in, g_in, b_in} = rgb;
  endtask

  // Hold one coordinate for three edges so the pipeline is filled with it.
  task automatic probe(input logic [9:0] x, input logic [9:0] y,
                       input logic [23:0] rgb);
    applyStimulus(x, y, rgb);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic writeCell0(input logic [4:0] addr, input logic [7:0] data);
    wr_valid0 = 1'b1;
    wr_addr0  = addr;
    wr_char0  = data;
    checkOutput($sformatf("wr0_ready_a%0d", addr), {31'd0, ready0}, 32'd1);
    @(posedge clk);
    #1;
    wr_valid0 = 1'b0;
  endtask

  task automatic writeCell1(input logic [5:0] addr, input logic [7:0] data);
    wr_valid1 = 1'b1;
    wr_addr1  = addr;
    wr_char1  = data;
    checkOutput($sformatf("wr1_ready_a%0d", addr), {31'd0, ready1}, 32'd1);
    @(posedge clk);
    #1;
    wr_valid1 = 1'b0;
  endtask

  task automatic pulseFrame();
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  // Counts edges until each busy falls (-1 if the bound expires). clr0 is
  // pulsed at iteration clr_at to show that it is ignored while clearing.
  task automatic countBusy(input int clr_at, output int n0, output int n1,
                           output int compl_err);
    n0 = -1;
    n1 = -1;
    compl_err = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      clr0 = (i == clr_at);
      if (ready0 === busy0) compl_err++;
      if (ready1 === busy1) compl_err++;
      if (n0 < 0 && !busy0) n0 = i;
      if (n1 < 0 && !busy1) n1 = i;
      if (n0 >= 0 && n1 >= 0) break;
    end
    clr0 = 1'b0;
  endtask

  task automatic addVec(input int x, input int y, input logic [23:0] rgb,
                        input logic [23:0] exp0, input logic [23:0] exp1);
    vec_t v;
    v.x    = 10'(x);
    v.y    = 10'(y);
    v.rgb  = rgb;
    v.exp0 = exp0;
    v.exp1 = exp1;
    vecs.push_back(v);
  endtask

  initial begin
    int n0, n1, cerr;
    logic [23:0] bg;
    logic [7:0]  arow;

    font_a = '{8'h18, 8'h3C, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h66, 8'h00};
    bg     = 24'h204080;

    // 'A' in dut0 cell 0; dut1 cell 0 stays space.
    for (int r = 0; r < 8; r++) begin
      arow = font_a[r];
      for (int c = 0; c < 8; c++) begin
        addVec(16 + c, 24 + r, 24'h000000,
               arow[7 - c] ? 24'hFFFFFF : 24'h000000, 24'h000000);
      end
    end
    // dut1 block at row 1 col 1 (2x scale): x 32..47, y 40..55.
    addVec(32, 40, bg, bg, 24'hFFFFFF);
    addVec(47, 55, bg, bg, 24'hFFFFFF);
    addVec(40, 48, bg, bg, 24'hFFFFFF);
    addVec(48, 40, bg, bg, bg);
    addVec(31, 40, bg, bg, bg);
    addVec(32, 39, bg, bg, bg);
    addVec(47, 56, bg, bg, bg);
    addVec(15, 24, bg, bg, bg);
    addVec(16, 23, bg, bg, bg);
    addVec(24, 24, bg, bg, bg);
    addVec(144, 24, bg, bg, bg);

    reset_n     = 1'b0;
    frame_start = 1'b0;
    wr_valid0   = 1'b0;
    wr_addr0    = '0;
    wr_char0    = '0;
    clr0        = 1'b0;
    wr_valid1   = 1'b0;
    wr_addr1    = '0;
    wr_char1    = '0;
    clr1        = 1'b0;
    applyStimulus(10'd19, 10'd24, 24'h123456);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_rgb0", {8'd0, r0, g0, b0}, 32'd0);
    checkOutput("rst_rgb1", {8'd0, r1, g1, b1}, 32'd0);
    checkOutput("rst_busy0", {31'd0, busy0}, 32'd1);
    checkOutput("rst_ready0", {31'd0, ready0}, 32'd0);
    checkOutput("rst_busy1", {31'd0, busy1}, 32'd1);
    checkOutput("rst_ready1", {31'd0, ready1}, 32'd0);

    reset_n = 1'b1;
    countBusy(0, n0, n1, cerr);
    checkOutput("init_clear_len0", n0, 32);
    checkOutput("init_clear_len1", n1, 40);
    checkOutput("init_busy_ready_compl", cerr, 0);
    checkOutput("init_ready0", {31'd0, ready0}, 32'd1);

    $display("[TB] cleared buffer passes input through");
    probe(10'd19, 10'd24, 24'h55AA33);
    checkOutput("blank_dut0", {8'd0, r0, g0, b0}, 32'h55AA33);
    probe(10'd40, 10'd48, 24'h55AA33);
    checkOutput("blank_dut1", {8'd0, r1, g1, b1}, 32'h55AA33);

    writeCell0(5'd0, 8'h0A);
    writeCell1(6'd21, 8'h14);
    writeCell1(6'd40, 8'h14);

    $display("[TB] pipeline latency");
    probe(10'd0, 10'd0, 24'h123456);
    checkOutput("lat_pre", {8'd0, r0, g0, b0}, 32'h123456);
    applyStimulus(10'd19, 10'd24, 24'h000000);
    @(posedge clk);
    #1;
    checkOutput("lat_edge1", {8'd0, r0, g0, b0}, 32'h123456);
    @(posedge clk);
    #1;
    checkOutput("lat_edge2", {8'd0, r0, g0, b0}, 32'h123456);
    @(posedge clk);
    #1;
    checkOutput("lat_edge3", {8'd0, r0, g0, b0}, 32'hFFFFFF);

    $display("[TB] vector table, %0d entries", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      probe(vecs[i].x, vecs[i].y, vecs[i].rgb);
      checkOutput($sformatf("vec%0d_dut0", i), {8'd0, r0, g0, b0}, {8'd0, vecs[i].exp0});
      checkOutput($sformatf("vec%0d_dut1", i), {8'd0, r1, g1, b1}, {8'd0, vecs[i].exp1});
    end

    $display("[TB] clear together with a write");
    wr_valid0 = 1'b1;
    wr_addr0  = 5'd1;
    wr_char0  = 8'h14;
    clr0      = 1'b1;
    checkOutput("clrwr_ready0", {31'd0, ready0}, 32'd1);
    @(posedge clk);
    #1;
    wr_valid0 = 1'b0;
    clr0      = 1'b0;
    checkOutput("clrwr_busy0", {31'd0, busy0}, 32'd1);
    countBusy(16, n0, n1, cerr);
    checkOutput("clr_len0", n0, 32);
    checkOutput("clr_busy_ready_compl", cerr, 0);
    probe(10'd27, 10'd27, bg);
    checkOutput("clr_cell1_space", {8'd0, r0, g0, b0}, {8'd0, bg});
    probe(10'd19, 10'd24, bg);
    checkOutput("clr_cell0_space", {8'd0, r0, g0, b0}, {8'd0, bg});

    $display("[TB] blink");
    writeCell0(5'd0, 8'h81);
    for (int f = 0; f <= 4; f++) begin
      probe(10'd19, 10'd24, 24'h000000);
      checkOutput($sformatf("blink_frame%0d", f), {8'd0, r0, g0, b0},
                  (f == 2 || f == 3) ? 32'h000000 : 32'hFFFFFF);
      if (f < 4) pulseFrame();
    end

    $display("[TB] reset during a clear");
    clr0 = 1'b1;
    @(posedge clk);
    #1;
    clr0 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("midclr_busy0", {31'd0, busy0}, 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_busy0", {31'd0, busy0}, 32'd1);
    checkOutput("midrst_ready1", {31'd0, ready1}, 32'd0);
    checkOutput("midrst_rgb0", {8'd0, r0, g0, b0}, 32'd0);
    #2;
    reset_n = 1'b1;
    countBusy(0, n0, n1, cerr);
    checkOutput("restart_len0", n0, 32);
    checkOutput("restart_len1", n1, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
